// File: rtl/load_store_unit.sv
// Purpose: single-outstanding load/store initiator for a word-wide, word-write-only data memory with 1-cycle read.
// Latency: error 1, word store 2, load 3, sub-word store (read-modify-write) 4 cycles from accept to resp_valid.
// Backpressure: req_ready only in IDLE; the response is held stable in RESP until resp_ready, stalling indefinitely.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   req_valid/req_ready            request handshake; req_store, req_size, req_unsigned, req_addr, req_wdata
//   resp_valid/resp_ready          response handshake; resp_rdata (extended load data), resp_err
//   mem_addr, mem_wdata,           registered memory strobes and word address/data
//   mem_read, mem_write
//   mem_rdata                      memory read data, valid the cycle after mem_read
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_RD = 3'd1,
        WAIT_RD  = 3'd2,
        ISSUE_WR = 3'd3,
        RESP     = 3'd4
    } state_t;

    // One extra bit so the limit itself is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS * 4);

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_store;
    logic        lat_uns;
    logic [15:0] lat_wdata;

    logic        accept;
    logic        bad_size;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept       = req_valid && req_ready && (state == IDLE);
    assign bad_size     = (req_size == 2'b11);
    assign misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign req_err      = bad_size || misaligned || out_of_range;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt = RESP;
                    end else if (req_store && (req_size == 2'b10)) begin
                        state_nxt = ISSUE_WR;
                    end else begin
                        state_nxt = ISSUE_RD;
                    end
                end
            end
            ISSUE_RD: state_nxt = WAIT_RD;
            WAIT_RD:  state_nxt = lat_store ? ISSUE_WR : RESP;
            ISSUE_WR: state_nxt = RESP;
            RESP:     if (resp_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Little-endian lane selection / extension for loads, lane insertion for sub-word stores.
    always_comb begin
        byte_lane = mem_rdata[{lat_off, 3'b000} +: 8];
        half_lane = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_size)
            2'b00:   load_data = {{24{~lat_uns & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{16{~lat_uns & half_lane[15]}}, half_lane};
            default: load_data = mem_rdata;
        endcase

        merged = mem_rdata;
        if (lat_size == 2'b00) begin
            merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
        end else if (lat_off[1]) begin
            merged[31:16] = lat_wdata;
        end else begin
            merged[15:0] = lat_wdata;
        end
    end

    // Registered outputs and latched request fields. Strobes and handshake flags are
    // derived from the state being entered so they line up exactly with that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_off    <= '0;
            lat_size   <= '0;
            lat_store  <= 1'b0;
            lat_uns    <= 1'b0;
            lat_wdata  <= '0;
        end else begin
            req_ready  <= (state_nxt == IDLE);
            resp_valid <= (state_nxt == RESP);
            mem_read   <= (state_nxt == ISSUE_RD);
            mem_write  <= (state_nxt == ISSUE_WR);

            if (accept) begin
                lat_off    <= req_addr[1:0];
                lat_size   <= req_size;
                lat_store  <= req_store;
                lat_uns    <= req_unsigned;
                lat_wdata  <= req_wdata[15:0];
                mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                // A word store writes req_wdata as-is; sub-word stores overwrite this in WAIT_RD.
                mem_wdata  <= req_wdata;
                resp_rdata <= '0;
                resp_err   <= req_err;
            end

            if (state == WAIT_RD) begin
                if (lat_store) begin
                    mem_wdata <= merged;
                end else begin
                    resp_rdata <= load_data;
                end
            end
        end
    end

endmodule
